adder_issue_stage: RTL and testbench
====================================

Name: adder_issue_stage

Overview:
- Operand issue stage directly upstream of the 32-bit ripple adder in the calculator pipeline.
- Buffers incoming operation requests in a small FIFO and pre-conditions the operands: two's-complement negation for SUB, accumulator substitution for ACC.
- Drives the adder's a/b inputs, captures the combinational sum into a registered, valid/ready result port.
- Owns the running accumulator register.

Parameters:
- DATA_W, 32 (from calculator_pkg): operand/result width.
- DEPTH, 4: request FIFO entries; power of two, >= 2.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  synchronous, active-low reset.
- in_valid_i  input  1  request valid.
- in_ready_o  output  1  request accepted when in_valid_i && in_ready_o.
- in_op_i  input  2  opcode: 0 ADD, 1 SUB, 2 ACC, 3 CLR.
- in_a_i  input  DATA_W  operand A.
- in_b_i  input  DATA_W  operand B.
- add_a_o  output  DATA_W  to adder a_i.
- add_b_o  output  DATA_W  to adder b_i.
- add_sum_i  input  DATA_W  from adder sum_o; combinational, same cycle.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  result consumed when out_valid_o && out_ready_i.
- out_data_o  output  DATA_W  result.
- acc_o  output  DATA_W  current accumulator value.

Behaviour:
- Reset (rst_ni == 0 at clock edge): FIFO empty, acc_o = 0, out_valid_o = 0, out_data_o = 0. in_ready_o = 0 while rst_ni is low. Reset mid-operation discards all queued and in-flight requests; no partial result is emitted.
- FIFO:
  - in_ready_o = !full (registered count, no combinational path from out_ready_i).
  - Push on in_valid_i && in_ready_o.
  - Simultaneous push and pop is allowed at any fill level except full, where push is blocked.
  - Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
  - Pushed entry is not issuable in the same cycle; minimum latency from acceptance to out_valid_o is 2 cycles.
- Issue condition: issue = !empty && (!out_valid_o || out_ready_i). Pop the head on issue.
- Operand mux (head entry, driven every cycle; all zeros when empty):
  - ADD: add_a_o = a, add_b_o = b.
  - SUB: add_a_o = a, add_b_o = (~b + 1) mod 2^DATA_W, computed inside this block.
  - ACC: add_a_o = acc, add_b_o = a; b is ignored.
  - CLR: add_a_o = 0, add_b_o = 0.
- On issue (same edge):
  - out_data_o <= add_sum_i and out_valid_o <= 1.
  - ACC: acc <= add_sum_i.
  - CLR: acc <= 0, result 0.
  - ADD/SUB: acc unchanged.
- Output hold: out_valid_o && !out_ready_i means out_data_o is held stable and nothing issues. If out_ready_i && !issue, out_valid_o <= 0.
- Arithmetic: all results are modulo 2^DATA_W; no carry or overflow indication. SUB of 0 gives add_b_o = 0.
- Back-to-back ACC ops see the acc updated by the previous issue (one issue per cycle, no hazard).
- Throughput: one result per cycle when out_ready_i is held high and the FIFO is non-empty.

Test Plan:
- Reset then ADD a=5, b=7 with out_ready_i=1 -> out_valid_o 2 cycles after acceptance, out_data_o=12, acc_o=0.
- SUB a=3, b=5 -> add_b_o=32'hFFFF_FFFB while issuing, out_data_o=32'hFFFF_FFFE. Then SUB a=0, b=0 -> 0.
- ACC a=10, ACC a=20, ACC a=32'hFFFF_FFFF issued back-to-back -> results 10, 30, 29 on consecutive cycles; acc_o=29. Then CLR -> result 0, acc_o=0.
- out_ready_i=0, push 5 requests -> 1 in the output register plus 4 in the FIFO, in_ready_o=0 and out_data_o held. Raise out_ready_i -> results drain in order one per cycle; in_ready_o reasserts the cycle after the first pop.
- Continuous push with out_ready_i=1 at full throughput -> no bubbles, count stays constant, pointers wrap past DEPTH with correct ordering over 20 ops.
- Assert rst_ni=0 for one cycle with 3 queued requests, out_valid_o=1 and acc=50 -> next cycle out_valid_o=0, acc_o=0, FIFO empty, and no stale results after release.

Source files
------------

// File: rtl/adder_issue_stage_if.sv
// Request, adder and result signals between the adder issue stage and its neighbours.
// The issue stage takes the slave view; the requester/consumer/adder side takes the master view.
interface adder_issue_stage_if #(
  parameter int DATA_W = 32
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [1:0]        in_op_i;
  logic [DATA_W-1:0] in_a_i;
  logic [DATA_W-1:0] in_b_i;
  logic [DATA_W-1:0] add_a_o;
  logic [DATA_W-1:0] add_b_o;
  logic [DATA_W-1:0] add_sum_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;
  logic [DATA_W-1:0] acc_o;

  modport slave (
    input  in_valid_i, in_op_i, in_a_i, in_b_i, add_sum_i, out_ready_i,
    output in_ready_o, add_a_o, add_b_o, out_valid_o, out_data_o, acc_o
  );

  modport master (
    output in_valid_i, in_op_i, in_a_i, in_b_i, add_sum_i, out_ready_i,
    input  in_ready_o, add_a_o, add_b_o, out_valid_o, out_data_o, acc_o
  );
endinterface

// File: rtl/adder_issue_stage.sv
// Operand issue stage for the ripple adder: request FIFO, operand pre-conditioning,
// registered valid/ready result and the running accumulator.
module adder_issue_stage #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  adder_issue_stage_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_ACC = 2'd2;
  localparam logic [1:0] OP_CLR = 2'd3;

  logic [1:0]        op_mem [DEPTH];
  logic [DATA_W-1:0] a_mem  [DEPTH];
  logic [DATA_W-1:0] b_mem  [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W:0]    count_reg;
  logic [DATA_W-1:0] acc_reg;
  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_reg;

  logic              empty;
  logic              full;
  logic              push;
  logic              issue;
  logic [1:0]        head_op;
  logic [DATA_W-1:0] head_a;
  logic [DATA_W-1:0] head_b;
  logic [DATA_W-1:0] add_a_next;
  logic [DATA_W-1:0] add_b_next;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == FULL_CNT);
  // Ready depends only on registered fill level, never on out_ready_i.
  assign bus.in_ready_o = rst_ni && !full;
  assign push    = bus.in_valid_i && bus.in_ready_o;
  assign issue   = !empty && (!out_valid_reg || bus.out_ready_i);

  assign head_op = op_mem[rd_ptr_reg];
  assign head_a  = a_mem[rd_ptr_reg];
  assign head_b  = b_mem[rd_ptr_reg];

  always_ff @(posedge clk_i) begin
    if (push) begin
      op_mem[wr_ptr_reg] <= bus.in_op_i;
      a_mem[wr_ptr_reg]  <= bus.in_a_i;
      b_mem[wr_ptr_reg]  <= bus.in_b_i;
    end
  end

  always_comb begin
    add_a_next = '0;
    add_b_next = '0;
    if (!empty) begin
      case (head_op)
        OP_ADD: begin
          add_a_next = head_a;
          add_b_next = head_b;
        end
        OP_SUB: begin
          add_a_next = head_a;
          add_b_next = (~head_b) + DATA_W'(1);
        end
        OP_ACC: begin
          add_a_next = acc_reg;
          add_b_next = head_a;
        end
        default: begin
          add_a_next = '0;
          add_b_next = '0;
        end
      endcase
    end
  end

  assign bus.add_a_o = add_a_next;
  assign bus.add_b_o = add_b_next;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      acc_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (issue) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, issue})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase

      if (issue) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= (head_op == OP_CLR) ? '0 : bus.add_sum_i;
        if (head_op == OP_ACC) begin
          acc_reg <= bus.add_sum_i;
        end else if (head_op == OP_CLR) begin
          acc_reg <= '0;
        end
      end else if (bus.out_ready_i) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.out_valid_o = out_valid_reg;
  assign bus.out_data_o  = out_data_reg;
  assign bus.acc_o       = acc_reg;
endmodule

// File: tb/tb_adder_issue_stage.sv
// Directed self-checking bench for adder_issue_stage; a plain behavioural adder closes the loop.
module tb_adder_issue_stage;
  localparam int DATA_W = 32;

  logic clk_i;
  logic rst_ni;
  int   vectors;
  int   miscompares;

  adder_issue_stage_if #(.DATA_W(DATA_W)) bus ();

  adder_issue_stage #(.DATA_W(DATA_W), .DEPTH(4)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  // Stand-in for the downstream ripple adder.
  assign bus.add_sum_i = bus.add_a_o + bus.add_b_o;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid_i = 1'b1;
    bus.in_op_i    = op;
    bus.in_a_i     = a;
    bus.in_b_i     = b;
    tick();
    bus.in_valid_i = 1'b0;
    $display("push op=%0d a=%h b=%h", op, a, b);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    tick();
    tick();
    vectors++;
    if (bus.out_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid_o);
    end
    vectors++;
    if (bus.out_data_o !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_out_data: got %h expected 00000000", bus.out_data_o);
    end
    vectors++;
    if (bus.acc_o !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_acc: got %h expected 00000000", bus.acc_o);
    end
    vectors++;
    if (bus.in_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_in_ready_low: got %b expected 0", bus.in_ready_o);
    end
    rst_ni = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready_release: got %b expected 1", bus.in_ready_o);
    end
    tick();
  endtask

  task automatic test_add();
    bus.out_ready_i = 1'b1;
    push_req(2'd0, 32'd5, 32'd7);
    vectors++;
    if (bus.out_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL add_latency_early: got %b expected 0", bus.out_valid_o);
    end
    tick();
    vectors++;
    if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 32'd12) begin
      miscompares++;
      $display("FAIL add_result: got v=%b d=%h expected v=1 d=0000000c", bus.out_valid_o, bus.out_data_o);
    end
    vectors++;
    if (bus.acc_o !== 32'h0) begin
      miscompares++;
      $display("FAIL add_acc: got %h expected 00000000", bus.acc_o);
    end
    tick();
    vectors++;
    if (bus.out_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL add_drain: got %b expected 0", bus.out_valid_o);
    end
  endtask

  task automatic test_sub();
    push_req(2'd1, 32'd3, 32'd5);
    vectors++;
    if (bus.add_a_o !== 32'd3 || bus.add_b_o !== 32'hFFFF_FFFB) begin
      miscompares++;
      $display("FAIL sub_operands: got a=%h b=%h expected a=00000003 b=fffffffb", bus.add_a_o, bus.add_b_o);
    end
    tick();
    vectors++;
    if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 32'hFFFF_FFFE) begin
      miscompares++;
      $display("FAIL sub_result: got v=%b d=%h expected v=1 d=fffffffe", bus.out_valid_o, bus.out_data_o);
    end
    push_req(2'd1, 32'd0, 32'd0);
    vectors++;
    if (bus.add_b_o !== 32'h0) begin
      miscompares++;
      $display("FAIL sub_zero_operand: got %h expected 00000000", bus.add_b_o);
    end
    tick();
    vectors++;
    if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 32'h0) begin
      miscompares++;
      $display("FAIL sub_zero_result: got v=%b d=%h expected v=1 d=00000000", bus.out_valid_o, bus.out_data_o);
    end
    tick();
  endtask

  task automatic test_acc();
    bus.in_valid_i = 1'b1;
    bus.in_op_i    = 2'd2;
    bus.in_b_i     = 32'hDEAD_BEEF;
    bus.in_a_i     = 32'd10;
    tick();
    bus.in_a_i     = 32'd20;
    tick();
    vectors++;
    if (bus.out_data_o !== 32'd10 || bus.acc_o !== 32'd10) begin
      miscompares++;
      $display("FAIL acc_first: got d=%h acc=%h expected 0000000a", bus.out_data_o, bus.acc_o);
    end
    bus.in_a_i     = 32'hFFFF_FFFF;
    tick();
    bus.in_valid_i = 1'b0;
    vectors++;
    if (bus.out_data_o !== 32'd30 || bus.acc_o !== 32'd30) begin
      miscompares++;
      $display("FAIL acc_second: got d=%h acc=%h expected 0000001e", bus.out_data_o, bus.acc_o);
    end
    tick();
    vectors++;
    if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 32'd29 || bus.acc_o !== 32'd29) begin
      miscompares++;
      $display("FAIL acc_third: got v=%b d=%h acc=%h expected v=1 0000001d", bus.out_valid_o, bus.out_data_o, bus.acc_o);
    end
    push_req(2'd3, 32'd77, 32'd88);
    tick();
    vectors++;
    if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 32'h0 || bus.acc_o !== 32'h0) begin
      miscompares++;
      $display("FAIL acc_clr: got v=%b d=%h acc=%h expected v=1 d=0 acc=0", bus.out_valid_o, bus.out_data_o, bus.acc_o);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_data;
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b1;
    bus.in_op_i     = 2'd0;
    bus.in_b_i      = 32'd100;
    for (int i = 1; i <= 5; i++) begin
      bus.in_a_i = i;
      vectors++;
      if (bus.in_ready_o !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_accept_%0d: got in_ready=%b expected 1", i, bus.in_ready_o);
      end
      tick();
    end
    bus.in_valid_i = 1'b0;
    vectors++;
    if (bus.in_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_full: got in_ready=%b expected 0", bus.in_ready_o);
    end
    tick();
    vectors++;
    if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 32'd101) begin
      miscompares++;
      $display("FAIL bp_hold: got v=%b d=%h expected v=1 d=00000065", bus.out_valid_o, bus.out_data_o);
    end
    bus.out_ready_i = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_ready_no_comb_path: got in_ready=%b expected 0", bus.in_ready_o);
    end
    for (int i = 2; i <= 5; i++) begin
      tick();
      exp_data = 32'd100 + i;
      vectors++;
      if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== exp_data || bus.in_ready_o !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_drain_%0d: got v=%b d=%h rdy=%b expected v=1 d=%h rdy=1",
                 i, bus.out_valid_o, bus.out_data_o, bus.in_ready_o, exp_data);
      end
    end
    tick();
    vectors++;
    if (bus.out_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_empty: got v=%b expected 0", bus.out_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [31:0] exp_data;
    logic [31:0] a;
    bus.out_ready_i = 1'b1;
    bus.in_valid_i  = 1'b1;
    bus.in_b_i      = 32'd1000;
    for (int i = 0; i < 20; i++) begin
      a = 32'(i * 3);
      bus.in_a_i  = a;
      bus.in_op_i = (i % 2 == 0) ? 2'd0 : 2'd1;
      exp_q.push_back((i % 2 == 0) ? a + 32'd1000 : a - 32'd1000);
      tick();
      if (i >= 1) begin
        exp_data = exp_q.pop_front();
        vectors++;
        if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== exp_data || bus.in_ready_o !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_%0d: got v=%b d=%h rdy=%b expected v=1 d=%h rdy=1",
                   i - 1, bus.out_valid_o, bus.out_data_o, bus.in_ready_o, exp_data);
        end
      end
    end
    bus.in_valid_i = 1'b0;
    tick();
    exp_data = exp_q.pop_front();
    vectors++;
    if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== exp_data) begin
      miscompares++;
      $display("FAIL b2b_last: got v=%b d=%h expected v=1 d=%h", bus.out_valid_o, bus.out_data_o, exp_data);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.out_ready_i = 1'b1;
    push_req(2'd2, 32'd50, 32'd0);
    tick();
    bus.out_ready_i = 1'b0;
    push_req(2'd0, 32'd1, 32'd1);
    push_req(2'd0, 32'd2, 32'd2);
    push_req(2'd0, 32'd3, 32'd3);
    vectors++;
    if (bus.out_valid_o !== 1'b1 || bus.acc_o !== 32'd50) begin
      miscompares++;
      $display("FAIL rstmid_setup: got v=%b acc=%h expected v=1 acc=00000032", bus.out_valid_o, bus.acc_o);
    end
    rst_ni = 1'b0;
    tick();
    vectors++;
    if (bus.out_valid_o !== 1'b0 || bus.acc_o !== 32'h0 || bus.in_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_cleared: got v=%b acc=%h rdy=%b expected v=0 acc=0 rdy=0",
               bus.out_valid_o, bus.acc_o, bus.in_ready_o);
    end
    vectors++;
    if (bus.add_a_o !== 32'h0 || bus.add_b_o !== 32'h0) begin
      miscompares++;
      $display("FAIL rstmid_fifo_empty: got a=%h b=%h expected 0 0", bus.add_a_o, bus.add_b_o);
    end
    rst_ni = 1'b1;
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (bus.out_valid_o !== 1'b0) begin
        miscompares++;
        $display("FAIL rstmid_stale_%0d: got v=%b d=%h expected v=0", i, bus.out_valid_o, bus.out_data_o);
      end
    end
    push_req(2'd0, 32'd9, 32'd9);
    tick();
    vectors++;
    if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 32'd18) begin
      miscompares++;
      $display("FAIL rstmid_after: got v=%b d=%h expected v=1 d=00000012", bus.out_valid_o, bus.out_data_o);
    end
    tick();
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    rst_ni          = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.in_op_i     = 2'd0;
    bus.in_a_i      = '0;
    bus.in_b_i      = '0;
    bus.out_ready_i = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_acc();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
